// File: rtl/cjb_param_const_unit_v.sv
// cjb_param_const_unit_v: loadable constant bank with a 1-cycle registered read and {C,N,V,Z} flags.
// Define CJB_CONST_SEQ_EN to add the rotating sequence register (Seq_Mode/Seq_Step).
module cjb_param_const_unit_v #(
   parameter int WIDTH     = 8,
   parameter int NUM_CONST = 4,
   parameter int SEL_W     = 2
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [SEL_W-1:0] Func_Sel,
   input  logic             Const_Req,
   input  logic             Ld_En,
   input  logic [SEL_W-1:0] Ld_Addr,
   input  logic [WIDTH-1:0] Ld_Data,
   input  logic             Seq_Mode,
   input  logic             Seq_Step,
   output logic             Const_Valid,
   output logic [WIDTH-1:0] Const_Result,
   output logic [3:0]       Const_CNVZ
);
   function automatic logic [WIDTH-1:0] rst_val(input int idx);
      logic [WIDTH-1:0] v;
      for (int b = 0; b < WIDTH; b++)
         v[b] = (idx == 3) || (idx == 1 && b % 2 == 0) || (idx == 2 && b % 2 == 1);
      return v;
   endfunction
   logic [WIDTH-1:0] bank_q [NUM_CONST];
   logic [WIDTH-1:0] bank_d [NUM_CONST];
   logic [WIDTH-1:0] rd, result_q;
   logic [3:0]       cnvz_q;
   logic             valid_q, bank_we;
`ifdef CJB_CONST_SEQ_EN
   logic [WIDTH-1:0] seq_q, seq_d;
   // A load in sequence mode targets the sequence register and wins over a step.
   always_comb
      seq_d = (Seq_Mode && Ld_En) ? Ld_Data :
              Seq_Step ? {seq_q[WIDTH-2:0], seq_q[WIDTH-1]} : seq_q;
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) seq_q <= {{(WIDTH-1){1'b0}}, 1'b1};
      else       seq_q <= seq_d;
   assign bank_we = Ld_En & ~Seq_Mode;
   assign rd      = Seq_Mode ? seq_q : bank_q[Func_Sel];
`else
   logic unused_seq;
   assign unused_seq = Seq_Mode ^ Seq_Step;
   assign bank_we    = Ld_En;
   assign rd         = bank_q[Func_Sel];
`endif
   always_comb begin
      bank_d = bank_q;
      if (bank_we) bank_d[Ld_Addr] = Ld_Data;
   end
   // Read uses bank_q, so a same-edge load returns the old value.
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         cnvz_q   <= 4'b0001;
         for (int i = 0; i < NUM_CONST; i++) bank_q[i] <= rst_val(i);
      end else begin
         valid_q <= Const_Req;
         bank_q  <= bank_d;
         if (Const_Req) begin
            result_q <= rd;
            cnvz_q   <= {1'b0, rd[WIDTH-1], 1'b0, ~|rd};
         end
      end
   assign Const_Valid  = valid_q;
   assign Const_Result = result_q;
   assign Const_CNVZ   = cnvz_q;
endmodule

// File: tb/tb_cjb_param_const_unit_v.sv
// tb_cjb_param_const_unit_v: scoreboard bench; expected outputs are queued at each edge and checked on the following falling edge.
module tb_cjb_param_const_unit_v;
   logic       Clock, Reset, Const_Req, Ld_En, Seq_Mode, Seq_Step;
   logic [1:0] Func_Sel, Ld_Addr;
   logic [7:0] Ld_Data;
   logic       Const_Valid;
   logic [7:0] Const_Result;
   logic [3:0] Const_CNVZ;
   typedef struct {
      logic       v;
      logic [7:0] r;
      logic [3:0] f;
   } exp_t;
   exp_t       sbq[$];
   exp_t       mon_e;
   logic [7:0] bank_m [4];
   logic [7:0] seq_m, last_r;
   logic [3:0] last_f;
   int         n_chk = 0, n_fail = 0;
   cjb_param_const_unit_v #(.WIDTH(8), .NUM_CONST(4), .SEL_W(2)) dut (
      .Clock(Clock), .Reset(Reset), .Func_Sel(Func_Sel), .Const_Req(Const_Req),
      .Ld_En(Ld_En), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Seq_Mode(Seq_Mode),
      .Seq_Step(Seq_Step), .Const_Valid(Const_Valid), .Const_Result(Const_Result),
      .Const_CNVZ(Const_CNVZ)
   );
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      bank_m[0] = 8'h00; bank_m[1] = 8'h55; bank_m[2] = 8'hAA; bank_m[3] = 8'hFF;
      seq_m = 8'h01; last_r = 8'h00; last_f = 4'b0001;
   endtask
   task automatic drv(input logic req, input logic [1:0] sel, input logic ld,
                      input logic [1:0] addr, input logic [7:0] data,
                      input logic mode = 1'b0, input logic stp = 1'b0);
      exp_t       e;
      logic [7:0] rd;
      Const_Req = req; Func_Sel = sel; Ld_En = ld; Ld_Addr = addr; Ld_Data = data;
      Seq_Mode = mode; Seq_Step = stp;
      @(posedge Clock);
`ifdef CJB_CONST_SEQ_EN
      rd = mode ? seq_m : bank_m[sel];
`else
      rd = bank_m[sel];
`endif
      if (req) begin
         last_r = rd;
         last_f = {1'b0, rd[7], 1'b0, rd == 8'h00};
      end
      e.v = req; e.r = last_r; e.f = last_f;
      sbq.push_back(e);
`ifdef CJB_CONST_SEQ_EN
      if (mode && ld) seq_m = data;
      else if (stp)   seq_m = {seq_m[6:0], seq_m[7]};
      if (ld && !mode) bank_m[addr] = data;
`else
      if (ld) bank_m[addr] = data;
`endif
      @(negedge Clock);
   endtask
   always @(negedge Clock)
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("valid", Const_Valid, mon_e.v);
         chk("result", Const_Result, mon_e.r);
         chk("cnvz", Const_CNVZ, mon_e.f);
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      Reset = 1'b1; Const_Req = 1'b1; Func_Sel = 2'd3; Ld_En = 1'b0; Ld_Addr = 2'd0;
      Ld_Data = 8'h00; Seq_Mode = 1'b0; Seq_Step = 1'b0;
      model_reset();
      #3;
      chk("rst_valid", Const_Valid, 1'b0);
      chk("rst_result", Const_Result, 8'h00);
      chk("rst_cnvz", Const_CNVZ, 4'b0001);
      @(negedge Clock);
      chk("rst_edge_valid", Const_Valid, 1'b0);
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) drv(1'b1, 2'(i), 1'b0, 2'd0, 8'h00);
      drv(1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
      drv(1'b0, 2'd1, 1'b0, 2'd0, 8'h00);
      drv(1'b1, 2'd2, 1'b1, 2'd2, 8'h3C);
      drv(1'b1, 2'd2, 1'b0, 2'd0, 8'h00);
      drv(1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      drv(1'b1, 2'd0, 1'b1, 2'd0, 8'h80, 1'b0, 1'b0);
      drv(1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) drv(1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      drv(1'b1, 2'd1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) drv(1'b1, 2'(i), 1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++)
         drv(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom));
      drv(1'b0, 2'd0, 1'b1, 2'd1, 8'h12);
      drv(1'b1, 2'd1, 1'b0, 2'd0, 8'h00);
      Const_Req = 1'b1; Func_Sel = 2'd1; Ld_En = 1'b0; Seq_Mode = 1'b0; Seq_Step = 1'b0;
      @(posedge Clock);
      #2 Reset = 1'b1;
      #1;
      chk("midrst_valid", Const_Valid, 1'b0);
      chk("midrst_result", Const_Result, 8'h00);
      chk("midrst_cnvz", Const_CNVZ, 4'b0001);
      @(posedge Clock);
      @(negedge Clock);
      chk("midrst_edge_valid", Const_Valid, 1'b0);
      Reset = 1'b0;
      model_reset();
      drv(1'b1, 2'd1, 1'b0, 2'd0, 8'h00);
      drv(1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      drv(1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
      repeat (2) @(negedge Clock);
      chk("sb_drain", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
